alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand/result width.
REQ-002 Parameter OPCODE_LENGTH, 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester request accepted this cycle.
REQ-007 req_srca0, req_srca1  input  DATA_WIDTH each  operand A per requester.
REQ-008 req_srcb0, req_srcb1  input  DATA_WIDTH each  operand B per requester.
REQ-009 req_op0, req_op1  input  OPCODE_LENGTH each  ALU operation per requester.
REQ-010 rsp_valid  output  2  result valid for requester i.
REQ-011 rsp_ready  input  2  requester i consumes result.
REQ-012 rsp_result  output  DATA_WIDTH  registered result, shared by both requesters.
REQ-013 alu_srca, alu_srcb  output  DATA_WIDTH each  to the shared ALU SrcA/SrcB.
REQ-014 alu_op  output  OPCODE_LENGTH  to the shared ALU Operation.
REQ-015 alu_result  input  DATA_WIDTH  from the shared ALU ALUResult (combinational).

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-017 IDLE: grant = only valid requester if one; if both valid, requester selected by priority pointer prio.
REQ-018 req_ready[i] = 1 only in IDLE and only for the granted i; combinational; never both bits high.
REQ-019 Handshake req_valid[i] & req_ready[i] at edge N: capture srca/srcb/op into op registers, latch owner = i, go EXEC.
REQ-020 alu_srca/alu_srcb/alu_op SHALL always drive the op registers (stable across all states, no glitching from requester inputs).
REQ-021 EXEC (one cycle, N+1): capture alu_result into rsp_result at end of cycle, go RESP.
REQ-022 RESP: rsp_valid[owner] = 1, other bit 0; rsp_result held constant until handshake.
REQ-023 Handshake rsp_valid[owner] & rsp_ready[owner]: go IDLE, prio = other requester; next grant possible same cycle IDLE is re-entered (one cycle after handshake).
REQ-024 Latency: accept at edge N -> rsp_valid high from cycle N+2; best-case throughput one op per 3 cycles.
REQ-025 rsp_ready low: stay in RESP indefinitely, no new request accepted, both req_ready low.
REQ-026 rsp_ready on non-owner bit ignored.
REQ-027 No request valid in IDLE: stay IDLE, prio unchanged.
REQ-028 Requester may drop req_valid before acceptance without effect; inputs sampled only on the accept edge.
REQ-029 Opcodes passed unmodified; arbiter does not interpret Operation or results; undefined opcodes yield whatever ALU returns (0).

Reset
REQ-030 reset high at an edge: state = IDLE, prio = requester 0, owner = 0, op registers = 0, rsp_result = 0.
REQ-031 During and after reset: req_ready = 0 while reset high, rsp_valid = 2'b00.
REQ-032 Reset mid-operation (EXEC or RESP) discards the in-flight op; no response is issued for it.

Structure
REQ-033 Shared package alu_arb_pkg holds the state enum (IDLE, EXEC, RESP) and named ALU opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0011, EQ 1000, XOR 1001, LT 1100, etc.).
REQ-034 One sub-module rr_arb2: combinational 2-way round-robin grant from req_valid and prio; arbiter FSM in alu_arbiter.
REQ-035 ALU not instantiated inside; connected at parent level.

Verification
REQ-036 Single req0 ADD, srca=5, srcb=7, rsp_ready=1 -> req_ready[0] at N, rsp_valid=2'b01 at N+2, rsp_result=12.
REQ-037 Both valid after reset: req0 SUB 10-3, req1 XOR 0xF0^0xFF -> req0 served first (result 7), then req1 (result 0x0F), then req0 again if still valid.
REQ-038 Backpressure: req1 OR 0x1|0x2, rsp_ready=0 for 5 cycles -> rsp_valid=2'b10 held, rsp_result=3 stable, req_ready=00 throughout.
REQ-039 Operand change after accept: req0 ADD 1+1 accepted, inputs changed to 100+100 next cycle -> alu_srca/srcb stay 1/1, result 2.
REQ-040 Reset asserted in RESP -> next cycle rsp_valid=00, rsp_result=0, state IDLE; subsequent req1 granted before req0 only if req0 not valid (prio=0).
REQ-041 Unknown opcode 4'b1111 with srca=9, srcb=9 -> response delivered normally, rsp_result=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding and the ALU operation codes seen on alu_op.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_LT  = 4'b1100;

    // Requester index to one-hot two-bit vector.
    function automatic logic [1:0] onehot2(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio.
// Purely combinational; the pointer itself lives in the parent FSM.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // Grant decode from the valid pair and the priority pointer
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = onehot2(prio);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU, one operation in flight.
// Operands are held in registers so the ALU inputs never follow requester wiggles.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [DATA_WIDTH-1:0]    req_srca0,
    input  logic [DATA_WIDTH-1:0]    req_srca1,
    input  logic [DATA_WIDTH-1:0]    req_srcb0,
    input  logic [DATA_WIDTH-1:0]    req_srcb1,
    input  logic [OPCODE_LENGTH-1:0] req_op0,
    input  logic [OPCODE_LENGTH-1:0] req_op1,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    state_e                   state_r;
    state_e                   state_next_s;
    logic                     prio_r;
    logic                     owner_r;
    logic [DATA_WIDTH-1:0]    srca_r;
    logic [DATA_WIDTH-1:0]    srcb_r;
    logic [OPCODE_LENGTH-1:0] op_r;
    logic [DATA_WIDTH-1:0]    result_r;
    logic [1:0]               rsp_valid_r;
    logic [1:0]               grant_s;
    logic                     accept_s;
    logic                     rsp_hs_s;

    rr_arb2 u_rr_arb2 (
        .req_valid (req_valid),
        .prio      (prio_r),
        .grant     (grant_s)
    );

    // Handshake qualifiers for the accept and response edges
    always_comb begin
        accept_s = 1'b0;
        rsp_hs_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            accept_s = |grant_s;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == RESP) begin
            rsp_hs_s = rsp_ready[owner_r];
        end else begin
            rsp_hs_s = 1'b0;
        end
    end

    // Ready is only offered to the granted requester while idle and out of reset
    always_comb begin
        req_ready = 2'b00;
        if ((state_r == IDLE) && !reset) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (|grant_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC:    state_next_s = RESP;
            RESP: begin
                if (rsp_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, owner and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                owner_r <= grant_s[1];
            end
            // The requester just served yields priority to the other one
            if (rsp_hs_s) begin
                prio_r <= ~owner_r;
            end
        end
    end

    // Operand registers loaded only on the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            srca_r <= '0;
            srcb_r <= '0;
            op_r   <= '0;
        end else if (accept_s) begin
            if (grant_s[1]) begin
                srca_r <= req_srca1;
                srcb_r <= req_srcb1;
                op_r   <= req_op1;
            end else begin
                srca_r <= req_srca0;
                srcb_r <= req_srcb0;
                op_r   <= req_op0;
            end
        end
    end

    // Result capture at the end of EXEC and response-valid tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= '0;
            rsp_valid_r <= 2'b00;
        end else if (state_r == EXEC) begin
            result_r    <= alu_result;
            rsp_valid_r <= onehot2(owner_r);
        end else if (rsp_hs_s) begin
            rsp_valid_r <= 2'b00;
        end
    end

    assign alu_srca   = srca_r;
    assign alu_srcb   = srcb_r;
    assign alu_op     = op_r;
    assign rsp_result = result_r;
    assign rsp_valid  = rsp_valid_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model driving alu_result.
// Inputs change and outputs are sampled 2-3 time units after the rising edge.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_srca0;
    logic [31:0] req_srca1;
    logic [31:0] req_srcb0;
    logic [31:0] req_srcb1;
    logic [3:0]  req_op0;
    logic [3:0]  req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;

    int n_cmp;
    int n_fail;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca0  (req_srca0),
        .req_srca1  (req_srca1),
        .req_srcb0  (req_srcb0),
        .req_srcb1  (req_srcb1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU: unknown opcodes return zero
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            OP_AND:  alu_result = alu_srca & alu_srcb;
            OP_OR:   alu_result = alu_srca | alu_srcb;
            OP_ADD:  alu_result = alu_srca + alu_srcb;
            OP_SUB:  alu_result = alu_srca - alu_srcb;
            OP_EQ:   alu_result = {31'd0, alu_srca == alu_srcb};
            OP_XOR:  alu_result = alu_srca ^ alu_srcb;
            OP_LT:   alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_srca0 = 32'd0;
        req_srca1 = 32'd0;
        req_srcb0 = 32'd0;
        req_srcb1 = 32'd0;
        req_op0   = 4'd0;
        req_op1   = 4'd0;
        rsp_ready = 2'b00;

        // Reset state, with a request pending to prove ready stays low
        tick();
        req_valid = 2'b01;
        tick();
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_srca", alu_srca, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        req_valid = 2'b00;
        reset = 1'b0;

        // Single req0 ADD 5+7
        req_srca0 = 32'd5;
        req_srcb0 = 32'd7;
        req_op0   = OP_ADD;
        rsp_ready = 2'b11;
        req_valid = 2'b01;
        #1;
        chk("add_req_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("add_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("add_exec_req_ready", {30'd0, req_ready}, 32'd0);
        chk("add_alu_srca", alu_srca, 32'd5);
        tick();
        chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("add_rsp_result", rsp_result, 32'd12);
        tick();
        chk("add_done_rsp_valid", {30'd0, rsp_valid}, 32'd0);

        // Reset again, then both valid: req0 first, req1 next, req0 again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_srca0 = 32'd10;
        req_srcb0 = 32'd3;
        req_op0   = OP_SUB;
        req_srca1 = 32'h0000_00F0;
        req_srcb1 = 32'h0000_00FF;
        req_op1   = OP_XOR;
        req_valid = 2'b11;
        #1;
        chk("both_first_ready", {30'd0, req_ready}, 32'd1);
        tick();
        chk("both_exec_ready", {30'd0, req_ready}, 32'd0);
        tick();
        chk("sub_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("sub_rsp_result", rsp_result, 32'd7);
        tick();
        chk("both_second_ready", {30'd0, req_ready}, 32'd2);
        tick();
        tick();
        chk("xor_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("xor_rsp_result", rsp_result, 32'h0000_000F);
        tick();
        chk("both_third_ready", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        tick();
        chk("idle_no_req_ready", {30'd0, req_ready}, 32'd0);

        // Backpressure on req1 OR 1|2; req0 ADD 1+1 waits alongside
        req_srca1 = 32'd1;
        req_srcb1 = 32'd2;
        req_op1   = OP_OR;
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        #1;
        chk("or_req_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_srca0 = 32'd1;
        req_srcb0 = 32'd1;
        req_op0   = OP_ADD;
        req_valid = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd2);
            chk("bp_rsp_result", rsp_result, 32'd3);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            if (k == 2) begin
                rsp_ready = 2'b01;
            end else begin
                rsp_ready = 2'b00;
            end
            tick();
        end
        chk("bp_hold_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        rsp_ready = 2'b10;
        tick();
        chk("bp_release_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("after_bp_ready", {30'd0, req_ready}, 32'd1);

        // Operand change after accept must not reach the ALU
        rsp_ready = 2'b11;
        tick();
        req_srca0 = 32'd100;
        req_srcb0 = 32'd100;
        req_valid = 2'b00;
        #1;
        chk("hold_alu_srca", alu_srca, 32'd1);
        chk("hold_alu_srcb", alu_srcb, 32'd1);
        chk("hold_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
        tick();
        chk("hold_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("hold_rsp_result", rsp_result, 32'd2);
        tick();

        // Unknown opcode passes through and yields zero
        req_srca0 = 32'd9;
        req_srcb0 = 32'd9;
        req_op0   = 4'b1111;
        req_valid = 2'b01;
        #1;
        chk("unk_req_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("unk_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("unk_rsp_result", rsp_result, 32'd0);
        chk("unk_alu_op", {28'd0, alu_op}, 32'd15);
        tick();

        // Reset while in RESP drops the response and restores prio to req0
        req_srca1 = 32'd4;
        req_srcb1 = 32'd4;
        req_op1   = OP_ADD;
        rsp_ready = 2'b00;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        chk("rr_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("rr_rsp_result", rsp_result, 32'd8);
        reset = 1'b1;
        req_valid = 2'b11;
        tick();
        chk("rr_req_ready_in_reset", {30'd0, req_ready}, 32'd0);
        chk("rr_rsp_valid_cleared", {30'd0, rsp_valid}, 32'd0);
        chk("rr_rsp_result_cleared", rsp_result, 32'd0);
        chk("rr_alu_srca_cleared", alu_srca, 32'd0);
        reset = 1'b0;
        #1;
        chk("rr_prio_reset", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b10;
        #1;
        chk("rr_only_req1", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        tick();
        chk("rr_final_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rr_final_req_ready", {30'd0, req_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
